// File: rtl/cotm_pkg.sv
// Shared types and constants for the clause convolution front end.
package cotm_pkg;

  localparam int IMG_W_DEFAULT     = 28;
  localparam int IMG_H_DEFAULT     = 28;
  localparam int MAX_PATCH_DEFAULT = 7;
  localparam int AW_DEFAULT        = 5;
  localparam int PSW               = 3;

  localparam logic [PSW-1:0] PS3 = 3'd3;
  localparam logic [PSW-1:0] PS5 = 3'd5;
  localparam logic [PSW-1:0] PS7 = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    LWAIT = 3'd2,
    SWEEP = 3'd3,
    NEXT  = 3'd4,
    NWAIT = 3'd5,
    DONE  = 3'd6
  } state_e;

  // Only odd patch sizes with a centre pixel are supported.
  function automatic logic ps_legal(input logic [PSW-1:0] ps);
    return (ps == PS3) || (ps == PS5) || (ps == PS7);
  endfunction

endpackage

// File: rtl/row_band_buffer.sv
// Band of image rows: indexed load, shift-up with insert at the band bottom,
// and a column read taken from the next-state contents so a row written this
// cycle is already visible in the column presented next cycle.
module row_band_buffer
  import cotm_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEFAULT,
  parameter int MAX_PATCH = MAX_PATCH_DEFAULT,
  parameter int AW        = AW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_en_i,
  input  logic [PSW-1:0]       ld_idx_i,
  input  logic                 shift_en_i,
  input  logic [PSW-1:0]       shift_len_i,
  input  logic [IMG_W-1:0]     wdata_i,
  input  logic [AW-1:0]        col_i,
  output logic [MAX_PATCH-1:0] col_o
);

  logic [IMG_W-1:0] row_q [MAX_PATCH];
  logic [IMG_W-1:0] row_d [MAX_PATCH];

  // Next-state rows plus the column slice of those next-state rows.
  always_comb begin
    for (int i = 0; i < MAX_PATCH; i++) begin
      row_d[i] = row_q[i];
    end
    if (ld_en_i) begin
      for (int i = 0; i < MAX_PATCH; i++) begin
        if (int'(ld_idx_i) == i) begin
          row_d[i] = wdata_i;
        end else begin
          row_d[i] = row_q[i];
        end
      end
    end else if (shift_en_i) begin
      for (int i = 0; i < MAX_PATCH - 1; i++) begin
        if (i < int'(shift_len_i) - 1) begin
          row_d[i] = row_q[i+1];
        end else begin
          row_d[i] = row_q[i];
        end
      end
      for (int i = 0; i < MAX_PATCH; i++) begin
        if (i == int'(shift_len_i) - 1) begin
          row_d[i] = wdata_i;
        end else begin
          row_d[i] = row_d[i];
        end
      end
    end else begin
      for (int i = 0; i < MAX_PATCH; i++) begin
        row_d[i] = row_q[i];
      end
    end
    col_o = '0;
    for (int i = 0; i < MAX_PATCH; i++) begin
      if (int'(col_i) < IMG_W) begin
        col_o[i] = row_d[i][col_i];
      end else begin
        col_o[i] = 1'b0;
      end
    end
  end

  // Row storage, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_PATCH; i++) begin
        row_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_PATCH; i++) begin
        row_q[i] <= row_d[i];
      end
    end
  end

endmodule

// File: rtl/patch_streamer.sv
// Streams a booleanized image to the clause convolution units: loads a band
// of patch_size rows, sweeps it column by column, then slides down one row.
// Every output is registered and derived from the next-state values, so
// ready is sampled at the edge that loads the output registers.
module patch_streamer
  import cotm_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEFAULT,
  parameter int IMG_H     = IMG_H_DEFAULT,
  parameter int MAX_PATCH = MAX_PATCH_DEFAULT,
  parameter int AW        = AW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           patch_size,
  input  logic                 ready,
  output logic                 mem_rd_en,
  output logic [AW-1:0]        mem_addr,
  input  logic [IMG_W-1:0]     mem_rdata,
  input  logic [IMG_W-1:0]     x_pos_mask,
  input  logic [IMG_H-1:0]     y_pos_mask,
  output logic [MAX_PATCH-1:0] pixels,
  output logic                 pe_enable,
  output logic                 conv_enable,
  output logic                 xmatch,
  output logic                 ymatch,
  output logic [AW-1:0]        patch_x,
  output logic [AW-1:0]        patch_y,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e         state_q, state_d;
  logic [PSW-1:0] ps_q, ps_d;
  logic [AW-1:0]  col_q, col_d, band_q, band_d;
  logic           rd_vld_q;
  logic [PSW-1:0] rd_idx_q;

  logic           adv_d, rd_en_d, done_d, err_d;
  logic [AW-1:0]  addr_d;
  logic           ld_en_s, shift_en_s;
  logic [MAX_PATCH-1:0] col_bits_s;

  logic [MAX_PATCH-1:0] pixels_d;
  logic           conv_d, xmatch_d, ymatch_d, busy_d;
  logic [AW-1:0]  patch_x_d, patch_y_d;

  logic           mem_rd_en_q, pe_enable_q, conv_enable_q, xmatch_q, ymatch_q;
  logic           busy_q, done_q, err_q;
  logic [AW-1:0]  mem_addr_q, patch_x_q, patch_y_q;
  logic [MAX_PATCH-1:0] pixels_q;

  row_band_buffer #(
    .IMG_W(IMG_W), .MAX_PATCH(MAX_PATCH), .AW(AW)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .ld_en_i    (ld_en_s),
    .ld_idx_i   (rd_idx_q),
    .shift_en_i (shift_en_s),
    .shift_len_i(ps_q),
    .wdata_i    (mem_rdata),
    .col_i      (col_d),
    .col_o      (col_bits_s)
  );

  // FSM next state, counters, read requests and buffer write controls.
  always_comb begin
    state_d    = state_q;
    ps_d       = ps_q;
    col_d      = col_q;
    band_d     = band_q;
    err_d      = err_q;
    rd_en_d    = 1'b0;
    addr_d     = mem_addr_q;
    adv_d      = 1'b0;
    done_d     = 1'b0;
    ld_en_s    = 1'b0;
    shift_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ps_d   = patch_size;
          col_d  = '0;
          band_d = '0;
          if (ps_legal(patch_size)) begin
            err_d   = 1'b0;
            state_d = LOAD;
            rd_en_d = 1'b1;
            addr_d  = '0;
          end else begin
            // Illegal sizes still take the settle cycle, so done follows
            // start by two cycles with no memory traffic.
            err_d   = 1'b1;
            state_d = LWAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        ld_en_s = rd_vld_q;
        if (mem_addr_q == AW'(ps_q - 3'd1)) begin
          state_d = LWAIT;
        end else begin
          rd_en_d = 1'b1;
          addr_d  = mem_addr_q + AW'(1);
        end
      end
      LWAIT: begin
        ld_en_s = rd_vld_q;
        if (err_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = SWEEP;
          col_d   = '0;
          adv_d   = ready;
        end
      end
      SWEEP: begin
        if (pe_enable_q) begin
          if (col_q == AW'(IMG_W)) begin
            if (band_q == AW'(IMG_H) - AW'(ps_q)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = NEXT;
              rd_en_d = 1'b1;
              addr_d  = band_q + AW'(ps_q);
            end
          end else begin
            col_d = col_q + AW'(1);
            adv_d = ready;
          end
        end else begin
          adv_d = ready;
        end
      end
      NEXT: begin
        state_d = NWAIT;
      end
      NWAIT: begin
        shift_en_s = 1'b1;
        band_d     = band_q + AW'(1);
        col_d      = '0;
        state_d    = SWEEP;
        adv_d      = ready;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the next cycle, taken from next-state counters.
  always_comb begin
    pixels_d = '0;
    for (int i = 0; i < MAX_PATCH; i++) begin
      if (adv_d && (i < int'(ps_q))) begin
        pixels_d[i] = col_bits_s[i];
      end else begin
        pixels_d[i] = 1'b0;
      end
    end
    conv_d = adv_d && (col_d >= AW'(ps_q));
    if ((state_d == SWEEP) && (col_d <= AW'(IMG_W) - AW'(ps_q))) begin
      xmatch_d = x_pos_mask[col_d];
    end else begin
      xmatch_d = 1'b0;
    end
    if (state_d == SWEEP) begin
      ymatch_d  = y_pos_mask[band_d];
      patch_x_d = col_d;
      patch_y_d = band_d;
    end else begin
      ymatch_d  = 1'b0;
      patch_x_d = '0;
      patch_y_d = '0;
    end
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ps_q          <= '0;
      col_q         <= '0;
      band_q        <= '0;
      rd_vld_q      <= 1'b0;
      rd_idx_q      <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      pixels_q      <= '0;
      pe_enable_q   <= 1'b0;
      conv_enable_q <= 1'b0;
      xmatch_q      <= 1'b0;
      ymatch_q      <= 1'b0;
      patch_x_q     <= '0;
      patch_y_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ps_q          <= ps_d;
      col_q         <= col_d;
      band_q        <= band_d;
      rd_vld_q      <= mem_rd_en_q;
      rd_idx_q      <= mem_addr_q[PSW-1:0];
      mem_rd_en_q   <= rd_en_d;
      mem_addr_q    <= addr_d;
      pixels_q      <= pixels_d;
      pe_enable_q   <= adv_d;
      conv_enable_q <= conv_d;
      xmatch_q      <= xmatch_d;
      ymatch_q      <= ymatch_d;
      patch_x_q     <= patch_x_d;
      patch_y_q     <= patch_y_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign pixels      = pixels_q;
  assign pe_enable   = pe_enable_q;
  assign conv_enable = conv_enable_q;
  assign xmatch      = xmatch_q;
  assign ymatch      = ymatch_q;
  assign patch_x     = patch_x_q;
  assign patch_y     = patch_y_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
